// File: rtl/uart_rx_sampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler_if
// Purpose : Groups the receive-sampler signals into one bundle.
//           "master" drives the synchronised serial line and the start pulse,
//           and consumes the received word, strobe and status flags.
//           "slave" is the sampler side.
// Signals : serial_in_synced  serial line, already synchronised, idle high
//           start_detected    one-cycle frame-start pulse
//           received_data     last received word, bit 0 = first data bit
//           data_valid        one-cycle strobe, word and flags updated
//           parity_error      last frame had odd parity
//           framing_error     stop bit of last frame sampled low
//           busy              sampler is inside a frame
// -----------------------------------------------------------------------------
interface uart_rx_sampler_if #(
    parameter int INPUT_DATA_WIDTH = 8
);
    logic                        serial_in_synced;
    logic                        start_detected;
    logic [INPUT_DATA_WIDTH-1:0] received_data;
    logic                        data_valid;
    logic                        parity_error;
    logic                        framing_error;
    logic                        busy;

    modport master (
        output serial_in_synced,
        output start_detected,
        input  received_data,
        input  data_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  serial_in_synced,
        input  start_detected,
        output received_data,
        output data_valid,
        output parity_error,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Purpose : Times mid-bit sample points from a start_detected pulse, confirms
//           the start bit, shifts in INPUT_DATA_WIDTH data bits LSB-first,
//           checks an optional even-parity bit and the stop bit, then presents
//           the word with a one-cycle data_valid strobe and error flags.
// Ports   : clk      system clock, posedge
//           reset_n  asynchronous active-low reset
//           bus      uart_rx_sampler_if.slave (line in, word/flags out)
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int CLOCKS_PER_BIT   = 5000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_rx_sampler_if.slave     bus
);
    localparam int W     = INPUT_DATA_WIDTH;
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = $clog2(INPUT_DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     shreg_q;
    logic             par_err_q;
    logic [W-1:0]     rdata_q;
    logic             valid_q;
    logic             perr_out_q;
    logic             ferr_out_q;
    logic             busy_q;

    logic [W-1:0]     shreg_d;
    logic             par_err_d;
    logic             bit_tick_d;

    // New bit enters at the MSB so that after W samples bit 0 is the first
    // bit seen on the line.
    generate
        if (W == 1) begin : g_shift_one
            assign shreg_d = bus.serial_in_synced;
        end else begin : g_shift_wide
            assign shreg_d = {bus.serial_in_synced, shreg_q[W-1:1]};
        end
    endgenerate

    // Even parity: the data bits plus the parity bit must XOR to zero.
    assign par_err_d  = (^shreg_q) ^ bus.serial_in_synced;
    assign bit_tick_d = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (bus.start_detected) begin
                        // The pulse cycle itself counts as tick 0, so the
                        // counter equals the cycle number while in START.
                        state_q   <= S_START;
                        cnt_q     <= CNT_ONE;
                        par_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (bus.serial_in_synced) begin
                            // Line went back high: glitch, not a start bit.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (bit_tick_d) begin
                        cnt_q   <= '0;
                        shreg_q <= shreg_d;
                        if (idx_q == IDX_LAST) begin
                            state_q <= (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_PARITY: begin
                    if (bit_tick_d) begin
                        cnt_q     <= '0;
                        par_err_q <= par_err_d;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (bit_tick_d) begin
                        rdata_q    <= shreg_q;
                        perr_out_q <= (PARITY_ENABLED != 0) ? par_err_q : 1'b0;
                        ferr_out_q <= ~bus.serial_in_synced;
                        valid_q    <= 1'b1;
                        // Leaving at mid stop bit lets a start pulse arriving
                        // right here be taken without losing a frame.
                        if (bus.start_detected) begin
                            state_q   <= S_START;
                            cnt_q     <= CNT_ONE;
                            par_err_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.received_data = rdata_q;
    assign bus.data_valid    = valid_q;
    assign bus.parity_error  = perr_out_q;
    assign bus.framing_error = ferr_out_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Purpose : Directed-vector bench for uart_rx_sampler with CLOCKS_PER_BIT=8,
//           8 data bits and even parity. Expected words are queued when a
//           frame starts; a monitor pops and compares on every data_valid.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;
    localparam int W = 8;
    localparam int P = 1;
    localparam int C = 8;
    localparam int FRAME_CYC = C * (W + 3);
    localparam int DV_CYC    = C / 2 + (W + 1 + P) * C + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_sampler_if #(.INPUT_DATA_WIDTH(W)) bus ();

    uart_rx_sampler #(
        .INPUT_DATA_WIDTH (W),
        .PARITY_ENABLED   (P),
        .CLOCKS_PER_BIT   (C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest queued frame.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            strobes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data_valid with data %0h, expected no strobe",
                         bus.received_data);
            end else begin
                mon_e = sb.pop_front();
                check("rx_data",       32'(bus.received_data), 32'(mon_e.data));
                check("parity_error",  32'(bus.parity_error),  32'(mon_e.perr));
                check("framing_error", 32'(bus.framing_error), 32'(mon_e.ferr));
                check("dv_cycle",      32'(cyc),               32'(mon_e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        bus.start_detected = 1'b0;
        bus.serial_in_synced = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one full frame; cycle t=0 is the start_detected cycle.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int spur_at, input int rst_at,
                              input logic exp_perr, input logic exp_ferr,
                              input bit expect_strobe);
        int bitn;
        for (int t = 0; t < FRAME_CYC; t++) begin
            @(posedge clk);
            #1;
            if (t == rst_at) begin
                bus.start_detected = 1'b0;
                reset_n = 1'b0;
                #1;
                check("rst_busy",  32'(bus.busy),          32'd0);
                check("rst_valid", 32'(bus.data_valid),    32'd0);
                check("rst_data",  32'(bus.received_data), 32'd0);
                bus.serial_in_synced = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                reset_n = 1'b1;
                return;
            end
            if (t == 0 && expect_strobe)
                sb.push_back('{data: d, perr: exp_perr, ferr: exp_ferr, cyc: cyc + DV_CYC});
            bus.start_detected = (t == 0) || (t == spur_at);
            bitn = t / C;
            if (bitn == 0)           bus.serial_in_synced = 1'b0;
            else if (bitn <= W)      bus.serial_in_synced = d[bitn-1];
            else if (bitn == W + 1)  bus.serial_in_synced = pbit;
            else                     bus.serial_in_synced = sbit;
            if (expect_strobe) begin
                if (t == 0)          check("busy_c0",  32'(bus.busy), 32'd0);
                if (t == 1)          check("busy_c1",  32'(bus.busy), 32'd1);
                if (t == DV_CYC - 1) check("busy_stop", 32'(bus.busy), 32'd1);
                if (t == DV_CYC)     check("busy_done", 32'(bus.busy), 32'd0);
            end
        end
        bus.start_detected = 1'b0;
        bus.serial_in_synced = 1'b1;
    endtask

    task automatic false_start();
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            bus.start_detected = (t == 0);
            bus.serial_in_synced = (t < 2) ? 1'b0 : 1'b1;
            if (t == 4) check("fs_busy_c4", 32'(bus.busy), 32'd1);
            if (t == 5) check("fs_busy_c5", 32'(bus.busy), 32'd0);
        end
        idle(100);
    endtask

    initial begin
        bus.serial_in_synced = 1'b1;
        bus.start_detected   = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  32'(bus.received_data), 32'd0);
        check("reset_valid", 32'(bus.data_valid),    32'd0);
        check("reset_perr",  32'(bus.parity_error),  32'd0);
        check("reset_ferr",  32'(bus.framing_error), 32'd0);
        check("reset_busy",  32'(bus.busy),          32'd0);
        reset_n = 1'b1;
        idle(5);

        // Clean 0xA5 (four ones, parity 0), parity error 0x01, framing error 0x3C.
        send_frame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
        idle(4);
        send_frame(8'h01, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1'b1);
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b1);
        idle(4);

        false_start();
        check("fs_hold_data", 32'(bus.received_data), 32'h3C);
        check("fs_hold_ferr", 32'(bus.framing_error), 32'd1);
        check("fs_hold_perr", 32'(bus.parity_error),  32'd0);

        // Back-to-back with a spurious start mid-frame 1.
        send_frame(8'h55, 1'b0, 1'b1, 40, -1, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Reset at cycle 40 of a frame, then a clean 0x81.
        send_frame(8'h81, 1'b0, 1'b1, -1, 40, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("post_rst_data", 32'(bus.received_data), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1);
        idle(10);

        check("sb_empty",    32'(sb.size()), 32'd0);
        check("strobe_count", 32'(strobes),  32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
